// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Function : Two-port data-memory arbiter (core LSU r0, loader/debug r1) with
//            a three-phase IDLE/ACCESS/RESP transaction sequence.
//            Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (r0 over r1);
//            default build uses round-robin.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int NUM_WORDS = 128,
    parameter int IDX_W     = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             r0_req,
    input  logic             r1_req,
    input  logic             r0_we,
    input  logic             r1_we,
    input  logic [31:0]      r0_addr,
    input  logic [31:0]      r1_addr,
    input  logic [31:0]      r0_wdata,
    input  logic [31:0]      r1_wdata,
    output logic             r0_gnt,
    output logic             r1_gnt,
    output logic             r0_rvalid,
    output logic             r1_rvalid,
    output logic             r0_err,
    output logic             r1_err,
    output logic [31:0]      rdata,
    output logic             memwrite,
    output logic             memread,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [29:0] c_words = 30'(NUM_WORDS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_we;
    logic        r_id;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        w_win;
    logic        w_grant;
    logic        w_oor;
    logic        w_acc;
    logic        w_resp;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_win = !r0_req;
`else
    // Pointer holds the id of the last granted requester; a tie goes to the other one.
    logic r_last;
    assign w_win = (r0_req && r1_req) ? ~r_last : r1_req;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`endif

    // Strobes are gated by reset so a transaction caught by reset is dropped cleanly.
    assign w_grant = reset_n && (r_state == S_IDLE) && (r0_req || r1_req);
    assign w_oor   = (r_addr[31:2] >= c_words) || (r_addr[1:0] != 2'b00);
    assign w_acc   = reset_n && (r_state == S_ACCESS) && !w_oor;
    assign w_resp  = reset_n && (r_state == S_RESP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r0_req || r1_req) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        r0_rvalid = 1'b0;
        r1_rvalid = 1'b0;
        r0_err    = 1'b0;
        r1_err    = 1'b0;
        r0_gnt    = w_grant && !w_win;
        r1_gnt    = w_grant && w_win;
        r0_rvalid = w_resp && !r_id;
        r1_rvalid = w_resp && r_id;
        r0_err    = w_resp && !r_id && w_oor;
        r1_err    = w_resp && r_id && w_oor;
    end

    assign memwrite  = w_acc && r_we;
    assign memread   = w_acc && !r_we;
    assign mem_addr  = r_addr[IDX_W+1:2];
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_id    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_id    <= w_win;
                r_we    <= w_win ? r1_we : r0_we;
                r_addr  <= w_win ? r1_addr : r0_addr;
                r_wdata <= w_win ? r1_wdata : r0_wdata;
            end
            if (r_state == S_ACCESS && !r_we) begin
                r_rdata <= w_oor ? 32'd0 : mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Function : Directed and randomized bench for dmem_arbiter, checked every
//            cycle against a transaction-timeline reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        r0_req, r1_req, r0_we, r1_we;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err;
    logic [31:0] rdata;
    logic        memwrite, memread;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] dut_mem [128];
    logic [31:0] ref_mem [128];

    int passed = 0;
    int total  = 0;

    dmem_arbiter #(.NUM_WORDS(128), .IDX_W(7)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .r0_req    (r0_req),
        .r1_req    (r1_req),
        .r0_we     (r0_we),
        .r1_we     (r1_we),
        .r0_addr   (r0_addr),
        .r1_addr   (r1_addr),
        .r0_wdata  (r0_wdata),
        .r1_wdata  (r1_wdata),
        .r0_gnt    (r0_gnt),
        .r1_gnt    (r1_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_rvalid (r1_rvalid),
        .r0_err    (r0_err),
        .r1_err    (r1_err),
        .rdata     (rdata),
        .memwrite  (memwrite),
        .memread   (memread),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = dut_mem[mem_addr];

    // Memory attached to the DUT, written only by DUT strobes.
    initial begin
        for (int i = 0; i < 128; i++) dut_mem[i] = 32'(i) * 32'h9E37_79B9;
        forever begin
            @(posedge clock);
            if (memwrite) dut_mem[mem_addr] = mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- reference model: transaction timeline ----------------
    int          cyc = 0;
    int          free_at = 0;
    int          acc_at = -1;
    int          rsp_at = -1;
    bit          last_id = 1'b1;
    bit          seen_reset = 1'b0;
    bit          t_id, t_we, t_oor;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] exp_rdata = 32'd0;

    initial begin
        int  win;
        bit  eg0, eg1, emw, emr, ev0, ev1, eerr;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        forever begin
            @(negedge clock);
            if (seen_reset) begin
                win = -1;
                eg0 = 0; eg1 = 0; emw = 0; emr = 0; ev0 = 0; ev1 = 0; eerr = 0;
                if (reset_n && cyc >= free_at && (r0_req || r1_req)) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    win = r0_req ? 0 : 1;
`else
                    if (r0_req && r1_req) win = last_id ? 0 : 1;
                    else win = r0_req ? 0 : 1;
`endif
                    eg0 = (win == 0);
                    eg1 = (win == 1);
                end
                if (reset_n && cyc == acc_at) begin
                    emw = t_we && !t_oor;
                    emr = !t_we && !t_oor;
                    chk("mem_addr", {25'd0, mem_addr}, {25'd0, t_addr[8:2]});
                    chk("mem_wdata", mem_wdata, t_wdata);
                end
                if (reset_n && cyc == rsp_at) begin
                    ev0  = !t_id;
                    ev1  = t_id;
                    eerr = t_oor;
                end
                chk1("r0_gnt", r0_gnt, eg0);
                chk1("r1_gnt", r1_gnt, eg1);
                chk1("memwrite", memwrite, emw);
                chk1("memread", memread, emr);
                chk1("r0_rvalid", r0_rvalid, ev0);
                chk1("r1_rvalid", r1_rvalid, ev1);
                chk1("r0_err", r0_err, ev0 && eerr);
                chk1("r1_err", r1_err, ev1 && eerr);
                chk("rdata", rdata, exp_rdata);
            end
            // Advance model across the coming clock edge.
            if (!reset_n) begin
                seen_reset = 1'b1;
                acc_at = -1; rsp_at = -1; free_at = cyc + 1;
                last_id = 1'b1; exp_rdata = 32'd0;
            end else if (seen_reset) begin
                if (win >= 0) begin
                    t_id    = (win == 1);
                    t_we    = t_id ? r1_we : r0_we;
                    t_addr  = t_id ? r1_addr : r0_addr;
                    t_wdata = t_id ? r1_wdata : r0_wdata;
                    t_oor   = (t_addr[31:9] != 0) || (t_addr[1:0] != 0);
                    acc_at  = cyc + 1; rsp_at = cyc + 2; free_at = cyc + 3;
                    last_id = t_id;
                end
                if (cyc == acc_at) begin
                    if (t_we && !t_oor) ref_mem[t_addr[8:2]] = t_wdata;
                    if (!t_we) exp_rdata = t_oor ? 32'd0 : ref_mem[t_addr[8:2]];
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input bit id, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        bit got = 1'b0;
        if (!id) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wd; end
        else     begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wd; end
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clock);
            got = id ? r1_gnt : r0_gnt;
        end
        chk1("gnt_wait", got, 1'b1);
        tick();
        if (!id) r0_req = 0; else r1_req = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            default: a = 32'($urandom_range(0, 15)) << 2;
        endcase
        return a;
    endfunction

    initial begin
        bit g0, g1, got;
        bit exp_tie [4];
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_tie = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_tie = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        reset_n = 0; r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
        r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1;
        @(negedge clock);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_mem_addr", {25'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk1("reset_rvalid", r0_rvalid | r1_rvalid, 1'b0);
        tick();

        // r0 store then load at 0x10
        issue(0, 1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clock);
        chk1("st_memwrite", memwrite, 1'b1);
        chk("st_mem_addr", {25'd0, mem_addr}, 32'd4);
        tick(); @(negedge clock);
        chk1("st_rvalid", r0_rvalid, 1'b1);
        tick();
        issue(0, 0, 32'h10, 32'h0);
        @(negedge clock);
        chk1("ld_memread", memread, 1'b1);
        tick(); @(negedge clock);
        chk1("ld_rvalid", r0_rvalid, 1'b1);
        chk("ld_rdata", rdata, 32'hDEAD_BEEF);
        tick();

        // r1 out-of-range load
        issue(1, 0, 32'h200, 32'h0);
        @(negedge clock);
        chk1("oor_strobe", memread | memwrite, 1'b0);
        tick(); @(negedge clock);
        chk1("oor_rvalid", r1_rvalid, 1'b1);
        chk1("oor_err", r1_err, 1'b1);
        chk("oor_rdata", rdata, 32'd0);
        tick();

        // four back-to-back ties
        r0_req = 1; r0_we = 0; r0_addr = 32'h10;
        r1_req = 1; r1_we = 0; r1_addr = 32'h14;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int i = 0; i < 6 && !got; i++) begin
                @(negedge clock);
                got = r0_gnt | r1_gnt;
            end
            chk1("tie_gnt_seen", got, 1'b1);
            chk1("tie_winner", r1_gnt, exp_tie[k]);
            tick();
        end
        r0_req = 0; r1_req = 0;
        repeat (3) tick();

        // misaligned r0 load
        issue(0, 0, 32'h06, 32'h0);
        @(negedge clock);
        chk1("mis_strobe", memread | memwrite, 1'b0);
        tick(); @(negedge clock);
        chk1("mis_err", r0_err, 1'b1);
        tick();

        // reset during ACCESS of an r1 store
        issue(1, 1, 32'h20, 32'h1234_5678);
        reset_n = 0;
        @(negedge clock);
        tick();
        reset_n = 1;
        r0_req = 1; r0_we = 0; r0_addr = 32'h10;
        r1_req = 1; r1_we = 0; r1_addr = 32'h14;
        @(negedge clock);
        chk1("abort_no_rvalid", r1_rvalid, 1'b0);
        chk1("abort_tie_r0", r0_gnt, 1'b1);
        tick();
        r0_req = 0; r1_req = 0;
        repeat (3) tick();

        // r0 request raised during RESP of r1
        issue(1, 0, 32'h14, 32'h0);
        tick();
        r0_req = 1; r0_we = 0; r0_addr = 32'h10;
        @(negedge clock);
        chk1("resp_no_gnt", r0_gnt, 1'b0);
        chk1("resp_r1_rvalid", r1_rvalid, 1'b1);
        tick(); @(negedge clock);
        chk1("idle_gnt", r0_gnt, 1'b1);
        tick();
        r0_req = 0;
        repeat (3) tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            g0 = r0_gnt; g1 = r1_gnt;
            tick();
            if (r0_req && (g0 || $urandom_range(0, 15) == 0)) r0_req = 0;
            else if (!r0_req && $urandom_range(0, 2) == 0) begin
                r0_req = 1; r0_we = 1'($urandom); r0_addr = rand_addr(); r0_wdata = $urandom;
            end
            if (r1_req && (g1 || $urandom_range(0, 15) == 0)) r1_req = 0;
            else if (!r1_req && $urandom_range(0, 2) == 0) begin
                r1_req = 1; r1_we = 1'($urandom); r1_addr = rand_addr(); r1_wdata = $urandom;
            end
            reset_n = ($urandom_range(0, 199) != 0);
        end
        reset_n = 1; r0_req = 0; r1_req = 0;
        repeat (4) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
